hazard_ctrl: RTL and testbench
==============================

// Module: hazard_ctrl
// PURPOSE
//  Control end of the ID->EXE pipeline register. Drives its stall and branch_taken (flush) inputs plus a global freeze.
//  Keeps a shadow of the destinations in flight in EXE, MEM and WB, and detects RAW hazards against the ID-stage sources.
//  Tracks multi-cycle SRAM accesses with a small FSM.
//  Sits beside the ID stage; one instance per core.
// PARAMETERS
//  REG_AW       5    register-index width
//  MEM_TIMEOUT  255  max consecutive MEM_WAIT cycles before mem_err
//  CNT_W        32   width of stall_cnt
// PORTS
//  clk          in   1       one clock, rising edge
//  rst          in   1       reset; asynchronous and active-low
//  id_valid     in   1       ID holds a real instruction
//  src1         in   REG_AW  ID source 1
//  src2         in   REG_AW  ID source 2
//  use_src2     in   1       src2 is read (0 for immediate forms)
//  dest_in      in   REG_AW  ID destination
//  WB_En_in     in   1       ID instruction writes back
//  MEM_R_En_in  in   1       ID instruction is a load
//  MEM_W_En_in  in   1       ID instruction is a store
//  branch_taken in   1       EXE resolved a taken branch
//  fwd_en       in   1       forwarding unit active
//  mem_ready    in   1       SRAM completes access this cycle
//  stall        out  1       hold IF and ID->EXE register, insert bubble
//  flush        out  1       clear IF/ID and ID->EXE registers
//  freeze       out  1       hold every pipeline register
//  mem_err      out  1       sticky: MEM_TIMEOUT exceeded
//  stall_cnt    out  CNT_W   cycles with stall=1
// BEHAVIOUR
//  - rst low: all shadow slots become bubbles (WB_En=0, MEM_R/W=0, dest=0). FSM=RUN, mem_err=0, stall_cnt=0.
//    stall, flush and freeze are forced to 0 while rst is low.
//  - Shadow slots EXE, MEM and WB each hold {dest, wb, mr, mw}.
//    A slot matches source s when wb=1, dest!=0 and dest==s.
//    src2 is checked only if use_src2=1. No check is made when id_valid=0.
//  - hazard:
//    - fwd_en=0: match in EXE or MEM slot. WB is excluded; the regfile writes on negedge.
//    - fwd_en=1: match in EXE slot with mr=1 only (load-use). One bubble.
//  - Priority: freeze > flush > stall.
//    - freeze = mem_busy, where mem_busy = MEM slot (mr|mw) & ~mem_ready.
//    - flush = branch_taken & ~freeze.
//    - stall = hazard & ~flush & ~freeze.
//  - Shadow advance on each clk when freeze=0:
//    - WB<=MEM, MEM<=EXE.
//    - EXE<=bubble if stall|flush|~id_valid, else the ID fields.
//  - freeze=1: all slots hold.
//  - FSM:
//    - RUN -> WAIT when mem_busy.
//    - WAIT -> RUN on mem_ready; the access completes that cycle and freeze drops combinationally.
//    - wait_cnt clears on entry to WAIT and increments each WAIT cycle.
//    - When wait_cnt reaches MEM_TIMEOUT, mem_err sets. It clears only on reset. The FSM stays in WAIT.
//  - stall_cnt increments when stall=1 and saturates at all-ones.
//  - Latency: stall, flush and freeze are same-cycle combinational from inputs and shadow state. Shadow lags by 1 clk.
//  - Simultaneous events:
//    - Stall and branch together: flush only; the ID instruction is squashed.
//    - Branch during freeze: flush deferred until freeze drops, since branch_taken remains asserted because EXE holds.
//  - Reset mid-WAIT: immediate return to RUN and the counter clears.
// STRUCTURE
//  - Shared package hazard_pkg:
//    - typedef slot_t {dest, wb, mr, mw}
//    - localparam BUBBLE
//    - FSM state enum {RUN, WAIT}
//  - One sub-module hazard_cmp (slot_t, src, chk -> match), instantiated 6x (3 slots x 2 sources).
//  - Top: shadow regs, FSM, counters.
// TESTING
//  1. No fwd: EXE slot {dest=3, wb=1}, ID src1=3 -> stall=1 for 2 cycles (EXE then MEM), 0 on 3rd; stall_cnt=2.
//  2. fwd_en=1: EXE load dest=5, ID src2=5, use_src2=1 -> stall=1 exactly 1 cycle.
//     Same with use_src2=0 -> stall=0.
//  3. Hazard + branch_taken same cycle -> flush=1, stall=0; next cycle EXE slot is bubble.
//  4. MEM slot load, mem_ready low 4 cycles -> freeze=1 for 4 cycles, slots unchanged; 5th cycle freeze=0, advance.
//  5. MEM_TIMEOUT=3, mem_ready held low -> mem_err=1 after 3 WAIT cycles, stays 1 after mem_ready.
//     Only rst clears it.
//  6. rst low during WAIT with stall_cnt=7 -> outputs 0, stall_cnt=0, mem_err=0, shadow bubbles; dest=0 never matches.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types for the hazard controller: shadow slot layout, bubble constant, SRAM wait FSM states.
package hazard_pkg;

  localparam int SLOT_AW = 5;

  typedef struct packed {
    logic [SLOT_AW-1:0] dest;
    logic               wb;
    logic               mr;
    logic               mw;
  } slot_t;

  localparam slot_t BUBBLE = '{dest: '0, wb: 1'b0, mr: 1'b0, mw: 1'b0};

  typedef enum logic {RUN, WAIT} mem_state_t;

endpackage

// File: rtl/hazard_cmp.sv
// RAW comparator: one shadow slot against one ID-stage source register.
module hazard_cmp
  import hazard_pkg::*;
(
  input  slot_t              slot,
  input  logic [SLOT_AW-1:0] src,
  input  logic               chk,
  output logic               match
);

  // r0 is hard-wired zero, so a write to it never creates a dependency
  assign match = chk & slot.wb & (slot.dest != '0) & (slot.dest == src);

  logic unused_mem_bits;
  assign unused_mem_bits = slot.mr ^ slot.mw;

endmodule

// File: rtl/hazard_ctrl.sv
// ID-stage hazard controller: EXE/MEM/WB destination shadow, RAW stall, branch flush, SRAM freeze.
//   state | meaning
//   RUN   | no SRAM access outstanding beyond the current cycle
//   WAIT  | MEM-stage access pending, wait_cnt counting toward mem_err
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_AW      = SLOT_AW,
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] src1,
  input  logic [REG_AW-1:0] src2,
  input  logic              use_src2,
  input  logic [REG_AW-1:0] dest_in,
  input  logic              WB_En_in,
  input  logic              MEM_R_En_in,
  input  logic              MEM_W_En_in,
  input  logic              branch_taken,
  input  logic              fwd_en,
  input  logic              mem_ready,
  output logic              stall,
  output logic              flush,
  output logic              freeze,
  output logic              mem_err,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam int WCW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WCW-1:0] TIMEOUT = WCW'(MEM_TIMEOUT);

  slot_t exe_s, mem_s, wb_s;
  slot_t slot_arr [3];
  slot_t id_slot;
  logic [1:0] match [3];
  logic [2:0] slot_hit, slot_use;
  logic hazard, mem_busy;
  mem_state_t state;
  logic [WCW-1:0] wait_cnt;

  assign slot_arr[0] = exe_s;
  assign slot_arr[1] = mem_s;
  assign slot_arr[2] = wb_s;
  assign id_slot = '{dest: dest_in, wb: WB_En_in, mr: MEM_R_En_in, mw: MEM_W_En_in};

  for (genvar i = 0; i < 3; i++) begin : g_slot
    for (genvar j = 0; j < 2; j++) begin : g_src
      hazard_cmp u_cmp (
        .slot  (slot_arr[i]),
        .src   ((j == 0) ? src1 : src2),
        .chk   ((j == 0) ? id_valid : (id_valid & use_src2)),
        .match (match[i][j])
      );
    end
  end

  // WB never counts: the regfile writes on negedge, so ID reads the new value
  assign slot_hit = {|match[2], |match[1], |match[0]};
  assign slot_use = {1'b0, ~fwd_en, 1'b1};
  assign hazard   = |(slot_hit & slot_use) & (~fwd_en | exe_s.mr);
  assign mem_busy = (mem_s.mr | mem_s.mw) & ~mem_ready;

  assign freeze = rst & mem_busy;
  assign flush  = rst & branch_taken & ~mem_busy;
  assign stall  = rst & hazard & ~branch_taken & ~mem_busy;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      exe_s <= BUBBLE;
      mem_s <= BUBBLE;
      wb_s  <= BUBBLE;
    end else if (!freeze) begin
      wb_s  <= mem_s;
      mem_s <= exe_s;
      exe_s <= (stall | flush | ~id_valid) ? BUBBLE : id_slot;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= RUN;
      wait_cnt <= '0;
      mem_err  <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (mem_busy) begin
            state    <= WAIT;
            wait_cnt <= '0;
          end
        end
        WAIT: begin
          if (mem_ready) begin
            state <= RUN;
          end else if (wait_cnt != TIMEOUT) begin
            wait_cnt <= wait_cnt + 1'b1;
            if (wait_cnt == TIMEOUT - 1'b1) mem_err <= 1'b1;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) stall_cnt <= '0;
    else if (stall && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed scenarios plus randomized traffic against an in-flight instruction model.
module tb_hazard_ctrl;

  localparam int AW = 5;
  localparam int TO = 3;
  localparam int CW = 4;

  logic clk = 1'b0;
  logic rst;
  logic id_valid, use_src2, wb_en, mr_en, mw_en, branch_taken, fwd_en, mem_ready;
  logic [AW-1:0] src1, src2, dest_in;
  logic stall, flush, freeze, mem_err;
  logic [CW-1:0] stall_cnt;

  hazard_ctrl #(.REG_AW(AW), .MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk          (clk),
    .rst          (rst),
    .id_valid     (id_valid),
    .src1         (src1),
    .src2         (src2),
    .use_src2     (use_src2),
    .dest_in      (dest_in),
    .WB_En_in     (wb_en),
    .MEM_R_En_in  (mr_en),
    .MEM_W_En_in  (mw_en),
    .branch_taken (branch_taken),
    .fwd_en       (fwd_en),
    .mem_ready    (mem_ready),
    .stall        (stall),
    .flush        (flush),
    .freeze       (freeze),
    .mem_err      (mem_err),
    .stall_cnt    (stall_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // instructions in flight: index 0 = EXE, 1 = MEM, 2 = WB
  int md [3];
  bit mwb [3], mmr [3], mmw [3];
  int busy_run;
  bit m_err;
  int m_cnt;
  bit e_stall, e_flush, e_freeze;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit writes(input int k, input int s);
    return mwb[k] && md[k] != 0 && md[k] == s;
  endfunction

  function automatic bit reads(input int k);
    return writes(k, int'(src1)) || (use_src2 && writes(k, int'(src2)));
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      md[k] = 0; mwb[k] = 0; mmr[k] = 0; mmw[k] = 0;
    end
    busy_run = 0;
    m_err = 0;
    m_cnt = 0;
  endtask

  task automatic model_comb();
    bit haz;
    if (!id_valid) haz = 0;
    else if (fwd_en) haz = mmr[0] && reads(0);
    else haz = reads(0) || reads(1);
    e_freeze = (mmr[1] || mmw[1]) && !mem_ready;
    e_flush  = branch_taken && !e_freeze;
    e_stall  = haz && !branch_taken && !e_freeze;
  endtask

  task automatic model_seq();
    if (e_stall && m_cnt < (1 << CW) - 1) m_cnt++;
    if (e_freeze) busy_run++;
    else busy_run = 0;
    // first busy cycle is spent entering WAIT, then TO waiting cycles
    if (busy_run >= TO + 1) m_err = 1;
    if (!e_freeze) begin
      for (int k = 2; k > 0; k--) begin
        md[k] = md[k-1]; mwb[k] = mwb[k-1]; mmr[k] = mmr[k-1]; mmw[k] = mmw[k-1];
      end
      if (e_stall || e_flush || !id_valid) begin
        md[0] = 0; mwb[0] = 0; mmr[0] = 0; mmw[0] = 0;
      end else begin
        md[0] = int'(dest_in); mwb[0] = wb_en; mmr[0] = mr_en; mmw[0] = mw_en;
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    model_comb();
    check_eq("stall", stall, e_stall);
    check_eq("flush", flush, e_flush);
    check_eq("freeze", freeze, e_freeze);
    check_eq("mem_err", mem_err, m_err);
    check_eq("stall_cnt", stall_cnt, m_cnt);
    @(posedge clk);
    model_seq();
    #1;
  endtask

  task automatic set_id(input bit v, input int s1, input int s2, input bit u2,
                        input int d, input bit wb, input bit mr, input bit mw);
    id_valid = v; src1 = AW'(s1); src2 = AW'(s2); use_src2 = u2;
    dest_in = AW'(d); wb_en = wb; mr_en = mr; mw_en = mw;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #2;
    check_eq("rst_stall", stall, 0);
    check_eq("rst_flush", flush, 0);
    check_eq("rst_freeze", freeze, 0);
    check_eq("rst_mem_err", mem_err, 0);
    check_eq("rst_stall_cnt", stall_cnt, 0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    int ready_pct;
    rst = 1'b0;
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    branch_taken = 0; fwd_en = 0; mem_ready = 1;
    model_reset();
    #12;
    check_eq("init_stall", stall, 0);
    check_eq("init_stall_cnt", stall_cnt, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;

    // RAW without forwarding: blocked while the writer sits in EXE and MEM
    set_id(1, 0, 0, 0, 3, 1, 0, 0);
    step();
    set_id(1, 3, 0, 0, 0, 0, 0, 0);
    step(); step(); step();
    check_eq("raw_stall_total", stall_cnt, 2);

    // load-use with forwarding, via src2, then the immediate form
    fwd_en = 1;
    set_id(1, 0, 0, 0, 5, 1, 1, 0);
    step();
    set_id(1, 0, 5, 1, 0, 0, 0, 0);
    step(); step();
    set_id(1, 0, 0, 0, 5, 1, 1, 0);
    step();
    set_id(1, 0, 5, 0, 0, 0, 0, 0);
    step();
    check_eq("imm_no_stall", stall_cnt, 3);

    // hazard and taken branch together
    fwd_en = 0;
    set_id(1, 0, 0, 0, 7, 1, 0, 0);
    step();
    set_id(1, 7, 0, 0, 9, 1, 0, 0);
    branch_taken = 1;
    step();
    branch_taken = 0;
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    step(); step();

    // load in MEM with a slow SRAM, long enough to trip the timeout
    set_id(1, 0, 0, 0, 4, 1, 1, 0);
    step();
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    mem_ready = 0;
    repeat (6) step();
    check_eq("timeout_sticky_pre", mem_err, 1);
    mem_ready = 1;
    step(); step();
    check_eq("timeout_sticky_post", mem_err, 1);

    // reset in the middle of a wait
    set_id(1, 0, 0, 0, 4, 1, 1, 0);
    step();
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    step();
    mem_ready = 0;
    step(); step();
    do_reset();
    mem_ready = 1;
    // writes to r0 never create a dependency
    set_id(1, 0, 0, 0, 0, 1, 0, 0);
    step();
    set_id(1, 0, 0, 1, 0, 0, 0, 0);
    step();

    ready_pct = 90;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (cyc % 200 == 0) begin
        case ($urandom_range(0, 2))
          0: ready_pct = 90;
          1: ready_pct = 50;
          default: ready_pct = 15;
        endcase
        fwd_en = $urandom_range(0, 1) == 1;
      end
      if (cyc % 700 == 699) do_reset();
      id_valid     = $urandom_range(0, 9) < 8;
      src1         = AW'($urandom_range(0, 3));
      src2         = AW'($urandom_range(0, 3));
      use_src2     = $urandom_range(0, 1) == 1;
      dest_in      = AW'($urandom_range(0, 3));
      wb_en        = $urandom_range(0, 3) != 0;
      begin
        int r;
        r = $urandom_range(0, 5);
        mr_en = r == 0;
        mw_en = r == 1;
      end
      branch_taken = $urandom_range(0, 9) == 0;
      mem_ready    = $urandom_range(0, 99) < ready_pct;
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
